// File: rtl/write_controller.sv
// ============================================================================
// Module   : write_controller
// Purpose  : Assembles UART write-request packets into a register write and
//            returns a one-byte acknowledge packet to the requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uartPkg;
  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;
endpackage

module write_controller
  import uartPkg::*;
#(
  parameter logic [7:0] WRITE_DEST  = 8'h01,
  parameter int         DATA_LENGTH = 5
) (
  input  logic        ipClk,
  input  logic        reset,
  input  UART_PACKET  ipRxStream,
  input  logic        ipTxReady,
  output UART_PACKET  opTxStream,
  output logic [7:0]  opWriteAddress,
  output logic [31:0] opWriteData,
  output logic        opWrite,
  output logic        opError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2,
    ACK    = 2'd3
  } stateT;

  // cnt value carried by the final data byte of a well-formed request
  localparam logic [1:0] LAST_CNT = 2'(DATA_LENGTH - 2);

  stateT       state, nState;
  logic [1:0]  cnt, nCnt;
  logic [7:0]  srcReg, nSrc;
  logic [7:0]  nAddr;
  logic [31:0] nData;
  logic        nWrite, nError;
  UART_PACKET  nTx;

  logic beat, destHit;
  logic unusedRx;

  assign beat     = ipRxStream.Valid;
  assign destHit  = (ipRxStream.Destination == WRITE_DEST);
  assign unusedRx = &{1'b0, ipRxStream.Length};

  always_ff @(posedge ipClk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      srcReg         <= 8'd0;
      opWriteAddress <= 8'd0;
      opWriteData    <= 32'd0;
      opWrite        <= 1'b0;
      opError        <= 1'b0;
      opTxStream     <= '0;
    end else begin
      state          <= nState;
      cnt            <= nCnt;
      srcReg         <= nSrc;
      opWriteAddress <= nAddr;
      opWriteData    <= nData;
      opWrite        <= nWrite;
      opError        <= nError;
      opTxStream     <= nTx;
    end
  end

  always_comb begin
    nState = state;
    nCnt   = cnt;
    nSrc   = srcReg;
    nAddr  = opWriteAddress;
    nData  = opWriteData;
    nWrite = 1'b0;
    nError = 1'b0;
    nTx    = '0;

    case (state)
      IDLE: begin
        if (beat && ipRxStream.SoP && destHit) begin
          if (ipRxStream.EoP) begin
            nError = 1'b1;
          end else begin
            nAddr  = ipRxStream.Data;
            nSrc   = ipRxStream.Source;
            nCnt   = 2'd0;
            nState = DATA;
          end
        end
      end

      DATA: begin
        if (beat) begin
          if (ipRxStream.SoP) begin
            // A fresh header abandons the partial request silently
            if (destHit && !ipRxStream.EoP) begin
              nAddr = ipRxStream.Data;
              nSrc  = ipRxStream.Source;
              nCnt  = 2'd0;
            end else begin
              nState = IDLE;
            end
          end else begin
            nData = {opWriteData[23:0], ipRxStream.Data};
            nCnt  = cnt + 2'd1;
            if (cnt == LAST_CNT) begin
              if (ipRxStream.EoP) begin
                nWrite = 1'b1;
                nState = COMMIT;
              end else begin
                nError = 1'b1;
                nState = IDLE;
              end
            end else if (ipRxStream.EoP) begin
              nError = 1'b1;
              nState = IDLE;
            end
          end
        end
      end

      COMMIT: begin
        nTx.Source      = WRITE_DEST;
        nTx.Destination = srcReg;
        nTx.Length      = 8'd1;
        nTx.SoP         = 1'b1;
        nTx.EoP         = 1'b1;
        nTx.Data        = opWriteAddress;
        nState          = ACK;
      end

      ACK: begin
        nTx       = opTxStream;
        nTx.Valid = ipTxReady;
        if (ipTxReady) begin
          nState = IDLE;
        end
      end

      default: begin
        nState = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_write_controller.sv
// ============================================================================
// Module   : tb_write_controller
// Purpose  : Randomized and directed checks of write_controller against a
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_controller;
  import uartPkg::*;

  localparam logic [7:0] WDEST = 8'h01;

  logic        ipClk = 1'b0;
  logic        reset = 1'b1;
  logic        ipTxReady = 1'b1;
  UART_PACKET  rxStream;
  UART_PACKET  txStream;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;
  logic        write;
  logic        error;

  write_controller #(.WRITE_DEST(WDEST), .DATA_LENGTH(5)) dut (
    .ipClk          (ipClk),
    .reset          (reset),
    .ipRxStream     (rxStream),
    .ipTxReady      (ipTxReady),
    .opTxStream     (txStream),
    .opWriteAddress (writeAddress),
    .opWriteData    (writeData),
    .opWrite        (write),
    .opError        (error)
  );

  always #5 ipClk = ~ipClk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a request is the bytes following a matching header,
  // judged when it reaches five bytes or ends early.
  bit          mInPkt = 1'b0;
  logic [7:0]  mQ[$];
  logic [7:0]  mSrc;
  logic [39:0] expW[$], obsW[$];
  logic [15:0] expAck[$], obsAck[$];
  int          expErr = 0, obsErr = 0;

  function automatic void modelBeat(input bit sop, input bit eop, input logic [7:0] dest,
                                    input logic [7:0] src, input logic [7:0] data);
    if (sop) begin
      if (dest == WDEST && !eop) begin
        mQ.delete();
        mQ.push_back(data);
        mSrc   = src;
        mInPkt = 1'b1;
      end else begin
        if (dest == WDEST && !mInPkt) expErr++;
        mInPkt = 1'b0;
      end
    end else if (mInPkt) begin
      mQ.push_back(data);
      if (mQ.size() == 5) begin
        if (eop) begin
          expW.push_back({mQ[0], mQ[1], mQ[2], mQ[3], mQ[4]});
          expAck.push_back({mSrc, mQ[0]});
        end else begin
          expErr++;
        end
        mInPkt = 1'b0;
      end else if (eop) begin
        expErr++;
        mInPkt = 1'b0;
      end
    end
  endfunction

  // Monitor
  int          cyc = 0;
  int          wrCyc = 0;
  int          lastAckLat = -1;
  logic        prevWrite = 1'b0;
  logic [39:0] lastW = '0;

  always @(posedge ipClk) cyc <= cyc + 1;

  always @(negedge ipClk) begin
    if (!reset) begin
      if (prevWrite) checkValue("wrHold", {24'd0, writeAddress, writeData}, {24'd0, lastW});
      if (write || error) checkValue("wrErrExcl", {63'd0, write & error}, 64'd0);
      if (write) begin
        checkValue("wrPulse", {63'd0, prevWrite}, 64'd0);
        obsW.push_back({writeAddress, writeData});
        lastW = {writeAddress, writeData};
        wrCyc = cyc;
      end
      if (error) obsErr++;
      if (txStream.Valid) begin
        checkValue("ackHdr", {46'd0, txStream.Source, txStream.Length, txStream.SoP, txStream.EoP},
                   {46'd0, WDEST, 8'd1, 1'b1, 1'b1});
        obsAck.push_back({txStream.Destination, txStream.Data});
        lastAckLat = cyc - wrCyc;
      end
    end
    prevWrite = write & ~reset;
  end

  task automatic sendBeat(input bit sop, input bit eop, input logic [7:0] dest,
                          input logic [7:0] src, input logic [7:0] data);
    @(negedge ipClk);
    rxStream.Source      = src;
    rxStream.Destination = dest;
    rxStream.Length      = 8'd5;
    rxStream.SoP         = sop;
    rxStream.EoP         = eop;
    rxStream.Data        = data;
    rxStream.Valid       = 1'b1;
    modelBeat(sop, eop, dest, src, data);
  endtask

  task automatic idleBeat();
    @(negedge ipClk);
    rxStream.Valid = 1'b0;
  endtask

  task automatic sendPkt(input logic [7:0] dest, input logic [7:0] src,
                         input logic [7:0] b[$], input bit withEop, input int maxGap);
    for (int i = 0; i < b.size(); i++) begin
      sendBeat(i == 0, withEop && (i == b.size() - 1), dest, src, b[i]);
      if (maxGap > 0) begin
        int g = $urandom_range(0, maxGap);
        for (int j = 0; j < g; j++) idleBeat();
      end
    end
    idleBeat();
  endtask

  task automatic settle(input int readyDelay);
    for (int i = 0; i < readyDelay; i++) @(negedge ipClk);
    ipTxReady = 1'b1;
    repeat (8) @(negedge ipClk);
  endtask

  task automatic compareAll(input string tag);
    checkValue({tag, "_nWrites"}, 64'(obsW.size()), 64'(expW.size()));
    for (int i = 0; i < obsW.size() && i < expW.size(); i++)
      checkValue({tag, "_write"}, {24'd0, obsW[i]}, {24'd0, expW[i]});
    checkValue({tag, "_nAcks"}, 64'(obsAck.size()), 64'(expAck.size()));
    for (int i = 0; i < obsAck.size() && i < expAck.size(); i++)
      checkValue({tag, "_ack"}, {48'd0, obsAck[i]}, {48'd0, expAck[i]});
    checkValue({tag, "_nErrors"}, 64'(obsErr), 64'(expErr));
    obsW.delete(); expW.delete(); obsAck.delete(); expAck.delete();
    obsErr = 0; expErr = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkValue(tag, {22'd0, write, error, writeAddress, writeData},
               64'd0);
    checkValue({tag, "_tx"}, {29'd0, txStream}, 64'd0);
  endtask

  initial begin
    logic [7:0] b[$];
    rxStream = '0;
    repeat (3) @(negedge ipClk);
    checkAllZero("resetState");
    reset = 1'b0;

    // Nominal write with immediate acknowledge
    b = '{8'h12, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sendPkt(WDEST, 8'h0A, b, 1'b1, 0);
    settle(0);
    checkValue("ackLatency", 64'(lastAckLat), 64'd2);
    compareAll("nominal");

    // Foreign destination
    sendPkt(8'h00, 8'h0A, b, 1'b1, 0);
    settle(0);
    compareAll("foreignDest");

    // Short packet, then a good one
    b = '{8'h12, 8'hDE, 8'hAD};
    sendPkt(WDEST, 8'h0A, b, 1'b1, 0);
    b = '{8'h34, 8'h01, 8'h02, 8'h03, 8'h04};
    sendPkt(WDEST, 8'h0B, b, 1'b1, 0);
    settle(0);
    compareAll("short");

    // Overlong packet
    b = '{8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sendPkt(WDEST, 8'h0A, b, 1'b1, 0);
    settle(0);
    compareAll("overlong");

    // Single-byte request
    b = '{8'h77};
    sendPkt(WDEST, 8'h0A, b, 1'b1, 0);
    settle(0);
    compareAll("oneByte");

    // Restart mid-packet
    b = '{8'h12, 8'hAA};
    sendPkt(WDEST, 8'h0A, b, 1'b0, 0);
    b = '{8'h56, 8'h01, 8'h02, 8'h03, 8'h04};
    sendPkt(WDEST, 8'h0C, b, 1'b1, 0);
    settle(0);
    compareAll("restart");

    // Transmitter back-pressure
    ipTxReady = 1'b0;
    b = '{8'h9A, 8'h10, 8'h20, 8'h30, 8'h40};
    sendPkt(WDEST, 8'h0D, b, 1'b1, 0);
    repeat (10) @(negedge ipClk);
    checkValue("noAckWhileBusy", 64'(obsAck.size()), 64'd0);
    settle(0);
    compareAll("backPressure");

    // Reset during DATA
    b = '{8'h12, 8'hDE};
    sendPkt(WDEST, 8'h0A, b, 1'b0, 0);
    @(negedge ipClk);
    reset = 1'b1;
    @(negedge ipClk);
    checkAllZero("midReset");
    reset = 1'b0;
    mInPkt = 1'b0;
    sendBeat(1'b0, 1'b0, WDEST, 8'h0A, 8'hAD);
    sendBeat(1'b0, 1'b0, WDEST, 8'h0A, 8'hBE);
    sendBeat(1'b0, 1'b1, WDEST, 8'h0A, 8'hEF);
    idleBeat();
    settle(0);
    compareAll("afterReset");

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      bit         prefix;
      logic [7:0] dest;
      int         len;
      prefix = ($urandom_range(0, 3) == 0);
      if (prefix) begin
        b.delete();
        for (int i = 0; i < $urandom_range(1, 3); i++) b.push_back(8'($urandom));
        sendPkt(WDEST, 8'($urandom), b, 1'b0, 1);
      end
      dest = ($urandom_range(0, 3) != 0) ? WDEST : 8'($urandom);
      len  = $urandom_range(prefix ? 2 : 1, 7);
      b.delete();
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      ipTxReady = 1'($urandom_range(0, 1));
      sendPkt(dest, 8'($urandom), b, 1'b1, $urandom_range(0, 2));
      settle($urandom_range(0, 4));
      compareAll("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
